// File: rtl/scratchpad_copy_engine.sv
// Block-copy master for the scratchpad memory port.
// Moves cmd_count elements of 2^cmd_len bytes from cmd_src to cmd_dst. Each
// element is one read followed by one write. The command is range- and
// alignment-checked before any access is made.
module scratchpad_copy_engine #(
  parameter int          CHUNK_SIZE      = 512,
  parameter int          NUM_CHUNKS      = 1024,
  parameter logic [63:0] SCRATCHPAD_BASE = 64'h0300000000000000,
  parameter int          RD_LATENCY      = 1,
  parameter int          COUNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [63:0]        cmd_src,
  input  logic [63:0]        cmd_dst,
  input  logic [COUNT_W-1:0] cmd_count,
  input  logic [1:0]         cmd_len,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               sp_en,
  output logic               sp_write,
  output logic [63:0]        sp_addr,
  output logic [1:0]         sp_len,
  output logic [63:0]        sp_wdata,
  input  logic [63:0]        sp_rdata
);

  localparam logic [64:0] SZ = 65'(CHUNK_SIZE) * 65'(NUM_CHUNKS);
  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LW-1:0] WLAST = LW'(RD_LATENCY - 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RD, S_WAIT, S_WR, S_FIN} state_t;

  state_t             r_state, w_next;
  logic [63:0]        r_src, r_dst, r_addr, r_wdata;
  logic [COUNT_W-1:0] r_count;
  logic [1:0]         r_len;
  logic               r_err;
  logic [LW-1:0]      r_wcnt;

  logic [63:0] w_step, w_mask;
  logic [64:0] w_bytes, w_lim, w_src_end, w_dst_end;
  logic        w_chk_err, w_accept, w_wlast;

  // Range/alignment check; 65-bit sums so an out-of-range end cannot wrap into range.
  assign w_step    = 64'd1 << r_len;
  assign w_mask    = w_step - 64'd1;
  assign w_bytes   = 65'(r_count) << r_len;
  assign w_lim     = {1'b0, SCRATCHPAD_BASE} + SZ;
  assign w_src_end = {1'b0, r_src} + w_bytes;
  assign w_dst_end = {1'b0, r_dst} + w_bytes;
  assign w_chk_err = (|(r_src & w_mask)) | (|(r_dst & w_mask)) |
                     (r_src < SCRATCHPAD_BASE) | (r_dst < SCRATCHPAD_BASE) |
                     (w_src_end > w_lim) | (w_dst_end > w_lim);

  assign w_accept = cmd_valid && (r_state == S_IDLE);
  assign w_wlast  = (r_wcnt == WLAST);

  // Outputs decode straight from state so an async reset drops sp_en at once.
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);
  assign err       = (r_state == S_FIN) && r_err;
  assign sp_en     = (r_state == S_RD) || (r_state == S_WR);
  assign sp_write  = (r_state == S_WR);
  assign sp_len    = r_len;
  assign sp_wdata  = r_wdata;
  // r_addr remembers the last driven address so sp_addr holds while idle.
  assign sp_addr   = (r_state == S_RD) ? r_src :
                     (r_state == S_WR) ? r_dst : r_addr;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_next = S_CHECK;
      S_CHECK: if (w_chk_err || (r_count == '0)) w_next = S_FIN;
               else                              w_next = S_RD;
      S_RD:    w_next = S_WAIT;
      S_WAIT:  if (w_wlast) w_next = S_WR;
      S_WR:    if (r_count == COUNT_W'(1)) w_next = S_FIN;
               else                        w_next = S_RD;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Command latch, address walk, element counter, read-latency counter and data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_count <= '0;
      r_len   <= '0;
      r_err   <= 1'b0;
      r_wcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_src   <= cmd_src;
          r_dst   <= cmd_dst;
          r_count <= cmd_count;
          r_len   <= cmd_len;
          r_err   <= 1'b0;
        end
        S_CHECK: r_err <= w_chk_err;
        S_RD: begin
          r_addr <= r_src;
          r_wcnt <= '0;
        end
        S_WAIT: begin
          r_wcnt <= r_wcnt + LW'(1);
          if (w_wlast) r_wdata <= sp_rdata;
        end
        S_WR: begin
          r_addr  <= r_dst;
          r_src   <= r_src + w_step;
          r_dst   <= r_dst + w_step;
          r_count <= r_count - COUNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
